// File: rtl/avr_prog_loader.sv
// Framed byte-stream loader that writes 16-bit words into AVR program memory.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module avr_prog_loader #(
   parameter int ADDR_W  = 9,
   parameter int DEPTH   = 512,
   parameter int TIMEOUT = 1000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [15:0]       pm_data,
   output logic              pm_write,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE, ERR
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          len_lo_q, len_lo_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [7:0]          lo_q, lo_d;
   logic [7:0]          sum_q, sum_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     wc_q, wc_d;
   logic [ADDR_W-1:0]   pm_addr_q, pm_addr_d;
   logic [15:0]         pm_data_q, pm_data_d;
   logic                pm_write_q, pm_write_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                accept;
   logic [15:0]         len_w;
   logic [7:0]          sum_w;

`ifdef LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]       tmo_q, tmo_d;
`endif

   // The write-strobe cycle is the only back-pressure; reset also blocks bytes.
   assign rx_ready = !RST && !pm_write_q;
   assign accept   = rx_valid && rx_ready;
   assign len_w    = {rx_data, len_lo_q};
   assign sum_w    = sum_q + rx_data;

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      len_d      = len_q;
      lo_d       = lo_q;
      sum_d      = sum_q;
      addr_d     = addr_q;
      wc_d       = wc_q;
      pm_addr_d  = pm_addr_q;
      pm_data_d  = pm_data_q;
      pm_write_d = 1'b0;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (accept && rx_data == 8'hA5) begin
               state_d = LEN_LO;
               done_d  = 1'b0;
               err_d   = 1'b0;
               wc_d    = '0;
               addr_d  = '0;
               sum_d   = 8'h00;
               hold_d  = 1'b1;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_lo_d = rx_data;
               sum_d    = sum_w;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               sum_d = sum_w;
               if (len_w == 16'd0 || len_w > 16'(DEPTH)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  len_d   = len_w[ADDR_W:0];
                  state_d = DATA_LO;
               end
            end
         end
         DATA_LO: begin
            if (accept) begin
               lo_d    = rx_data;
               sum_d   = sum_w;
               state_d = DATA_HI;
            end
         end
         DATA_HI: begin
            if (accept) begin
               sum_d      = sum_w;
               pm_write_d = 1'b1;
               pm_data_d  = {rx_data, lo_q};
               pm_addr_d  = addr_q;
               addr_d     = addr_q + 1'b1;
               wc_d       = wc_q + 1'b1;
               state_d    = (wc_q + 1'b1 == len_q) ? CHECK : DATA_LO;
            end
         end
         CHECK: begin
            if (accept) begin
               if (sum_w == 8'h00) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef LOADER_TIMEOUT_EN
      // Counts idle cycles only while a frame is open; any accepted byte restarts it.
      tmo_d = '0;
      if (state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK} && !accept) begin
         tmo_d = tmo_q + 1'b1;
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
            tmo_d   = '0;
         end
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         len_lo_q   <= '0;
         len_q      <= '0;
         lo_q       <= '0;
         sum_q      <= '0;
         addr_q     <= '0;
         wc_q       <= '0;
         pm_addr_q  <= '0;
         pm_data_q  <= '0;
         pm_write_q <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         len_q      <= len_d;
         lo_q       <= lo_d;
         sum_q      <= sum_d;
         addr_q     <= addr_d;
         wc_q       <= wc_d;
         pm_addr_q  <= pm_addr_d;
         pm_data_q  <= pm_data_d;
         pm_write_q <= pm_write_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef LOADER_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign pm_addr    = pm_addr_q;
   assign pm_data    = pm_data_q;
   assign pm_write   = pm_write_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = err_q;
   assign word_count = wc_q;

endmodule
